// File: rtl/lsu_pkg.sv
// LSU memory adapter shared types.
// Op, size, exception and memo encodings plus the FSM state.
package lsu_pkg;

    localparam int LSU_XLEN = 64;

    typedef enum logic [1:0] {
        OP_LOAD    = 2'd0,
        OP_STORE   = 2'd1,
        OP_AMOSWAP = 2'd2,
        OP_AMOADD  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        EXC_OK       = 2'b00,
        EXC_MISALIGN = 2'b01,
        EXC_FAULT    = 2'b10
    } exc_e;

    localparam logic [1:0] MEMO_RD = 2'b00;
    localparam logic [1:0] MEMO_WR = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    typedef struct packed {
        op_e                 op;
        logic [LSU_XLEN-1:0] addr;
        size_e               size;
        logic                sgn;
        logic [LSU_XLEN-1:0] wdata;
    } lsu_req_t;

    function automatic logic [7:0] byte_mask(input size_e size);
        logic [7:0] m;
        m = 8'h00;
        unique case (size)
            SZ_B: m = 8'h01;
            SZ_H: m = 8'h03;
            SZ_W: m = 8'h0f;
            SZ_D: m = 8'hff;
        endcase
        return m;
    endfunction

    function automatic logic misaligned(
        input logic [2:0] lo,
        input size_e      size
    );
        logic r;
        r = 1'b0;
        unique case (size)
            SZ_B: r = 1'b0;
            SZ_H: r = lo[0];
            SZ_W: r = |lo[1:0];
            SZ_D: r = |lo[2:0];
        endcase
        return r;
    endfunction

    function automatic logic [LSU_XLEN-1:0] trunc(
        input logic [LSU_XLEN-1:0] d,
        input size_e               size
    );
        logic [LSU_XLEN-1:0] r;
        r = d;
        unique case (size)
            SZ_B: r = {56'd0, d[7:0]};
            SZ_H: r = {48'd0, d[15:0]};
            SZ_W: r = {32'd0, d[31:0]};
            SZ_D: r = d;
        endcase
        return r;
    endfunction

    function automatic logic is_amo(input op_e op);
        return (op == OP_AMOSWAP) || (op == OP_AMOADD);
    endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Truncates a read value to the access size and
// sign- or zero-extends it back to 64 bits.
module lsu_load_extend
    import lsu_pkg::*;
(
    input  logic [LSU_XLEN-1:0] data,
    input  size_e               size,
    input  logic                sgn,
    output logic [LSU_XLEN-1:0] ext
);

    always_comb begin
        ext = data;
        unique case (size)
            SZ_B: ext = {{56{sgn & data[7]}}, data[7:0]};
            SZ_H: ext = {{48{sgn & data[15]}}, data[15:0]};
            SZ_W: ext = {{32{sgn & data[31]}}, data[31:0]};
            SZ_D: ext = data;
        endcase
    end

endmodule

// File: rtl/lsu_mem_adapter.sv
// Bridges core load/store/AMO requests onto a single-port
// byte-addressed RAM with combinational read data.
module lsu_mem_adapter
    import lsu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [XLEN-1:0] req_addr,
    input  logic [1:0]      req_size,
    input  logic            req_signed,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_data,
    output logic [1:0]      rsp_exc,
    output logic            mem_enable,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_data,
    output logic [1:0]      mem_memo,
    output logic [7:0]      mem_mask,
    input  logic [XLEN-1:0] mem_resp,
    input  logic [1:0]      mem_exc
);

    state_e          state;
    lsu_req_t        rq;
    logic [XLEN-1:0] rdat;
    exc_e            exc;
    logic [XLEN-1:0] ext_val;
    logic [XLEN-1:0] add_val;
    logic [XLEN-1:0] wr_val;
    op_e             in_op;
    size_e           in_size;

    assign in_op   = op_e'(req_op);
    assign in_size = size_e'(req_size);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            rq    <= '0;
            rdat  <= '0;
            exc   <= EXC_OK;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        rq <= '{
                            op:    in_op,
                            addr:  req_addr,
                            size:  in_size,
                            sgn:   req_signed,
                            wdata: req_wdata
                        };
                        rdat <= '0;
                        exc  <= EXC_OK;
                        if (is_amo(in_op) &&
                            misaligned(req_addr[2:0], in_size)) begin
                            exc   <= EXC_MISALIGN;
                            state <= S_RESP;
                        end else if (in_op == OP_STORE) begin
                            state <= S_WRITE;
                        end else begin
                            state <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    rdat <= mem_resp;
                    exc  <= exc_e'(mem_exc);
                    if (mem_exc != EXC_OK || rq.op == OP_LOAD)
                        state <= S_RESP;
                    else
                        state <= S_WRITE;
                end
                S_WRITE: begin
                    exc   <= exc_e'(mem_exc);
                    state <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    lsu_load_extend u_ext (
        .data (rdat),
        .size (rq.size),
        .sgn  (rq.sgn),
        .ext  (ext_val)
    );

    // AMOADD operates on the size-truncated old value
    assign add_val = trunc(trunc(rdat, rq.size) + rq.wdata, rq.size);

    always_comb begin
        wr_val = rq.wdata;
        unique case (1'b1)
            (rq.op == OP_AMOADD): wr_val = add_val;
            default:              wr_val = rq.wdata;
        endcase
    end

    assign req_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);
    assign rsp_exc   = rsp_valid ? exc : EXC_OK;
    assign rsp_data  = (rsp_valid && exc == EXC_OK &&
                        rq.op != OP_STORE) ? ext_val : '0;
    assign mem_addr  = rq.addr;

    // write enable is gated live by the RAM's exception
    always_comb begin
        mem_enable = 1'b0;
        mem_memo   = MEMO_RD;
        mem_mask   = 8'h00;
        mem_data   = '0;
        if (state == S_WRITE) begin
            mem_memo   = MEMO_WR;
            mem_mask   = byte_mask(rq.size);
            mem_data   = wr_val;
            mem_enable = (mem_exc == EXC_OK);
        end
    end

endmodule
